// File: rtl/result_scheduler.sv
// result_scheduler: round-robin arbiter feeding 3-word hit records (x, y, candidate) into a shared result store
//
// Optional feature: define MERGE_EN to fold requesters with the winner's (x,y) into one record.
//
// Ports:
//   clk, reset (sync, active-low)
//   req / req_x / req_y    : per-scale hit request level and packed coordinates
//   o_ack                  : one-cycle capture pulse per served requester
//   o_write_result         : store write strobe, high for the 3 record words
//   o_ori_x/o_ori_y/o_candidate : latched record contents
//   write_result_end       : store end-of-record pulse, expected on the last word
//   read_result            : consumer read strobe mirrored from the store
//   o_used / o_full        : store occupancy in words and no-room-for-a-record flag
//   o_busy / o_err         : not-idle flag and sticky protocol error
module result_scheduler #(
    parameter int DATA_WIDTH_12 = 12,
    parameter int NUM_RESIZE    = 5,
    parameter int FIFO_DEPTH    = 4096,
    parameter int CNT_WIDTH     = 13
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_RESIZE-1:0]              req,
    input  logic [NUM_RESIZE*DATA_WIDTH_12-1:0] req_x,
    input  logic [NUM_RESIZE*DATA_WIDTH_12-1:0] req_y,
    output logic [NUM_RESIZE-1:0]              o_ack,
    output logic                               o_write_result,
    output logic [DATA_WIDTH_12-1:0]           o_ori_x,
    output logic [DATA_WIDTH_12-1:0]           o_ori_y,
    output logic [NUM_RESIZE-1:0]              o_candidate,
    input  logic                               write_result_end,
    input  logic                               read_result,
    output logic [CNT_WIDTH-1:0]               o_used,
    output logic                               o_full,
    output logic                               o_busy,
    output logic                               o_err
);
    localparam int IW = (NUM_RESIZE > 1) ? $clog2(NUM_RESIZE) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            rr_q, rr_d, win_q, win_d, win;
    logic [1:0]               idx_q, idx_d;
    logic [DATA_WIDTH_12-1:0] x_q, x_d, y_q, y_d;
    logic [NUM_RESIZE-1:0]    cand_q, cand_d, sel_mask;
    logic [CNT_WIDTH-1:0]     used_q, used_d;
    logic                     err_q, err_d, found, wr, rd;
    int                       p;

    // First asserted requester at or after the round-robin pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        p     = 0;
        for (int k = 0; k < NUM_RESIZE; k++) begin
            p = int'(rr_q) + k;
            if (p >= NUM_RESIZE) p = p - NUM_RESIZE;
            if (!found && req[p]) begin
                found = 1'b1;
                win   = IW'(p);
            end
        end
    end

`ifdef MERGE_EN
    // Every asserted requester carrying the winner's coordinates (winner included) joins the record.
    always_comb begin
        sel_mask = '0;
        for (int j = 0; j < NUM_RESIZE; j++)
            sel_mask[j] = req[j]
                && req_x[j*DATA_WIDTH_12 +: DATA_WIDTH_12] == req_x[int'(win)*DATA_WIDTH_12 +: DATA_WIDTH_12]
                && req_y[j*DATA_WIDTH_12 +: DATA_WIDTH_12] == req_y[int'(win)*DATA_WIDTH_12 +: DATA_WIDTH_12];
    end
`else
    assign sel_mask = NUM_RESIZE'(1) << win;
`endif

    assign o_full         = used_q > CNT_WIDTH'(FIFO_DEPTH - 3);
    assign o_busy         = state_q != IDLE;
    assign o_write_result = state_q == WRITE;
    assign o_ack          = (state_q == GRANT) ? cand_q : '0;
    assign o_ori_x        = x_q;
    assign o_ori_y        = y_q;
    assign o_candidate    = cand_q;
    assign o_used         = used_q;
    assign o_err          = err_q;

    assign wr = state_q == WRITE;
    assign rd = read_result && used_q != '0;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        cand_d  = cand_q;
        used_d  = used_q + CNT_WIDTH'(wr) - CNT_WIDTH'(rd);
        // End-of-record must coincide with the last word; a read of an empty store is also a fault.
        err_d   = err_q
                | (wr && idx_q == 2'd2 && !write_result_end)
                | (write_result_end && !(wr && idx_q == 2'd2))
                | (read_result && used_q == '0);
        unique case (state_q)
            IDLE: if (found && !o_full) begin
                state_d = GRANT;
                win_d   = win;
                x_d     = req_x[int'(win)*DATA_WIDTH_12 +: DATA_WIDTH_12];
                y_d     = req_y[int'(win)*DATA_WIDTH_12 +: DATA_WIDTH_12];
                cand_d  = sel_mask;
            end
            GRANT: begin
                state_d = WRITE;
                idx_d   = 2'd0;
                rr_d    = (win_q == IW'(NUM_RESIZE - 1)) ? '0 : win_q + 1'b1;
            end
            WRITE: begin
                idx_d   = idx_q + 2'd1;
                state_d = (idx_q == 2'd2) ? IDLE : WRITE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cand_q  <= '0;
            used_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cand_q  <= cand_d;
            used_q  <= used_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_result_scheduler.sv
// tb_result_scheduler: directed self-checking bench for result_scheduler
module tb_result_scheduler;
    localparam int W = 12;
    localparam int N = 5;
    localparam int C = 13;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_x, req_y;
    logic [N-1:0]   o_ack, o_candidate;
    logic           o_write_result, o_full, o_busy, o_err;
    logic [W-1:0]   o_ori_x, o_ori_y;
    logic [C-1:0]   o_used;
    logic           write_result_end, read_result, end_en;
    logic [1:0]     wcnt;
    int             errors = 0;
    int             checks = 0;
    int             acks;

    always #5 clk = ~clk;

    result_scheduler dut (
        .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
        .o_ack(o_ack), .o_write_result(o_write_result), .o_ori_x(o_ori_x), .o_ori_y(o_ori_y),
        .o_candidate(o_candidate), .write_result_end(write_result_end), .read_result(read_result),
        .o_used(o_used), .o_full(o_full), .o_busy(o_busy), .o_err(o_err)
    );

    // Store model: pulses end-of-record on the third consecutive write word when enabled.
    always @(posedge clk) wcnt <= (!reset || !o_write_result) ? 2'd0 : wcnt + 2'd1;
    assign write_result_end = end_en && o_write_result && wcnt == 2'd2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; req = '0; req_x = '0; req_y = '0; read_result = 1'b0; end_en = 1'b1;
        do_reset();
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_used", 32'(o_used), 0);
        chk("rst_ack", 32'(o_ack), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_full", 32'(o_full), 0);

        // Single request on scale 2
        req_x[2*W +: W] = 12'h010; req_y[2*W +: W] = 12'h020; req = 5'b00100;
        tick();
        chk("s_ack", 32'(o_ack), 32'b00100);
        chk("s_wr_grant", 32'(o_write_result), 0);
        req = '0;
        tick();
        chk("s_wr0", 32'(o_write_result), 1);
        chk("s_x", 32'(o_ori_x), 32'h010);
        chk("s_y", 32'(o_ori_y), 32'h020);
        chk("s_cand", 32'(o_candidate), 32'b00100);
        chk("s_ack_off", 32'(o_ack), 0);
        tick();
        tick();
        chk("s_wr2", 32'(o_write_result), 1);
        chk("s_x2", 32'(o_ori_x), 32'h010);
        tick();
        chk("s_idle", 32'(o_busy), 0);
        chk("s_used", 32'(o_used), 3);
        chk("s_err", 32'(o_err), 0);

        // Round robin from pointer 0 with 10011 held: 0, 1, 4, 0
        do_reset();
        req = 5'b10011;
        tick();
        chk("rr_0", 32'(o_ack), 32'b00001);
        repeat (4) tick();
        tick();
        chk("rr_1", 32'(o_ack), 32'b00010);
        repeat (4) tick();
        tick();
        chk("rr_4", 32'(o_ack), 32'b10000);
        repeat (4) tick();
        tick();
        chk("rr_0b", 32'(o_ack), 32'b00001);
        repeat (4) tick();
        req = '0;
        chk("rr_used", 32'(o_used), 12);
        chk("rr_err", 32'(o_err), 0);

        // Reset during the second WRITE cycle
        req = 5'b01000;
        tick();
        req = '0;
        tick();
        tick();
        chk("mr_wr1", 32'(o_write_result), 1);
        reset = 1'b0;
        tick();
        chk("mr_wr", 32'(o_write_result), 0);
        chk("mr_used", 32'(o_used), 0);
        chk("mr_busy", 32'(o_busy), 0);
        chk("mr_x", 32'(o_ori_x), 0);
        chk("mr_cand", 32'(o_candidate), 0);
        reset = 1'b1;
        tick();
        chk("mr_noack", 32'(o_ack), 0);
        chk("mr_busy2", 32'(o_busy), 0);

        // Missing end-of-record sets a sticky error
        end_en = 1'b0;
        req = 5'b00010;
        tick();
        req = '0;
        tick();
        tick();
        chk("e_mid", 32'(o_err), 0);
        tick();
        tick();
        chk("e_set", 32'(o_err), 1);
        end_en = 1'b1;
        req = 5'b00001;
        tick();
        req = '0;
        repeat (4) tick();
        chk("e_sticky", 32'(o_err), 1);
        chk("e_used", 32'(o_used), 6);

        // Read of an empty store is ignored and flagged
        do_reset();
        read_result = 1'b1;
        tick();
        read_result = 1'b0;
        chk("re_used", 32'(o_used), 0);
        chk("re_err", 32'(o_err), 1);

        // Fill to the full threshold, then drain two words to reopen grants
        do_reset();
        req = 5'b00001;
        for (int i = 0; i < 8000 && !(o_used == 13'd4095 && !o_busy); i++) tick();
        chk("f_used", 32'(o_used), 4095);
        chk("f_full", 32'(o_full), 1);
        chk("f_err", 32'(o_err), 0);
        read_result = 1'b1;
        tick();
        read_result = 1'b0;
        chk("f_4094", 32'(o_used), 4094);
        chk("f_full2", 32'(o_full), 1);
        acks = 0;
        repeat (5) begin
            tick();
            acks += (o_ack != '0) ? 1 : 0;
        end
        chk("f_noack", 32'(acks), 0);
        read_result = 1'b1;
        tick();
        chk("f_4093", 32'(o_full), 0);
        tick();
        read_result = 1'b0;
        chk("f_4092", 32'(o_used), 4092);
        chk("f_grant", 32'(o_ack), 32'b00001);
        req = '0;
        repeat (4) tick();
        chk("f_refill", 32'(o_used), 4095);

        // Two requesters with identical coordinates
        do_reset();
        req_x[1*W +: W] = 12'h055; req_y[1*W +: W] = 12'h066;
        req_x[3*W +: W] = 12'h055; req_y[3*W +: W] = 12'h066;
        req = 5'b01010;
        tick();
`ifdef MERGE_EN
        chk("m_ack", 32'(o_ack), 32'b01010);
        req = '0;
        tick();
        chk("m_cand", 32'(o_candidate), 32'b01010);
        repeat (3) tick();
        chk("m_used", 32'(o_used), 3);
        tick();
        chk("m_noack", 32'(o_ack), 0);
`else
        chk("m_ack", 32'(o_ack), 32'b00010);
        req = 5'b01000;
        tick();
        chk("m_cand", 32'(o_candidate), 32'b00010);
        repeat (3) tick();
        tick();
        chk("m_ack2", 32'(o_ack), 32'b01000);
        req = '0;
        tick();
        chk("m_cand2", 32'(o_candidate), 32'b01000);
        repeat (3) tick();
        chk("m_used", 32'(o_used), 6);
`endif
        chk("m_err", 32'(o_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
